// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART word loader.
// Build option: UART_LOADER_PARITY_EN selects 8E1 framing (adds StParity).
package uart_loader_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned BYTES_PER_WORD       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
`ifdef UART_LOADER_PARITY_EN
    ,
    StParity
`endif
  } rx_state_e;

endpackage

// File: rtl/uart_word_loader_if.sv
// RAM write port in the flag/addr/data form shared with the DMA engine.
interface uart_word_loader_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              RAM_write_flag;
  logic [ADDR_W-1:0] RAM_write_addr;
  logic [DATA_W-1:0] RAM_write_data;

  modport master (
    output RAM_write_flag,
    output RAM_write_addr,
    output RAM_write_data
  );

  modport slave (
    input RAM_write_flag,
    input RAM_write_addr,
    input RAM_write_data
  );
endinterface

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: rx synchroniser, bit timer and frame FSM.
// Build option: UART_LOADER_PARITY_EN checks an even-parity bit before the stop bit.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       enable,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  rx_state_e       state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            half_tick, bit_tick, cnt_clr, par_bad;

  assign half_tick = (cnt_q == HalfCnt);
  assign bit_tick  = (cnt_q == FullCnt);
  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      // Dropping the enable aborts any frame in flight.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (!rx_s_q) state_d = StStart;
        StStart:    if (half_tick) state_d = rx_s_q ? StIdle : StData;
        StData: begin
          if (bit_tick && (bit_q == 3'd7)) begin
`ifdef UART_LOADER_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
`ifdef UART_LOADER_PARITY_EN
        StParity:   if (bit_tick) state_d = StStop;
`endif
        StStop:     if (bit_tick) state_d = rx_s_q ? StIdle : StWaitHigh;
        StWaitHigh: if (rx_s_q) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (enable && (state_q == StStop) && bit_tick) begin
      byte_valid = rx_s_q && !par_bad;
      byte_err   = !rx_s_q || par_bad;
    end
    cnt_clr = (state_q == StIdle) || (state_q == StWaitHigh) || (state_d != state_q) || bit_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_clr ? '0 : cnt_q + CntW'(1);
      if (state_q == StStart) begin
        bit_q <= '0;
      end
      if ((state_q == StData) && bit_tick) begin
        shift_q <= {rx_s_q, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

`ifdef UART_LOADER_PARITY_EN
  logic par_err_q;

  // Even parity: data bits plus parity bit must have an even count of ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if ((state_q == StParity) && bit_tick) begin
      par_err_q <= ^{shift_q, rx_s_q};
    end
  end

  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: rtl/uart_word_loader.sv
// UART image loader: packs received bytes into little-endian words and writes them to RAM.
// Build option: UART_LOADER_PARITY_EN (8E1 framing in the byte receiver).
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned GAP_BITS     = 32
) (
  input  logic               physical_clock,
  input  logic               n_reset,
  input  logic               rx,
  input  logic               load_enb,
  input  logic [ADDR_W-1:0]  base_addr,
  uart_word_loader_if.master ram,
  output logic               busy,
  output logic [ADDR_W-1:0]  word_count,
  output logic               frame_err
);

  localparam int unsigned IdxW      = $clog2(BYTES_PER_WORD);
  localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GapW      = $clog2(GapCycles + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  logic              byte_valid, byte_err, rx_busy;
  logic [7:0]        rx_byte;
  logic              en_q, en_rise, en_fall;
  logic [IdxW-1:0]   byte_idx_q;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] base_q, count_q, addr_q;
  logic [DATA_W-1:0] data_q;
  logic              flag_q, frame_err_q;
  logic [GapW-1:0]   gap_q;
  logic              gap_expire;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (physical_clock),
    .rst_n     (n_reset),
    .rx        (rx),
    .enable    (load_enb),
    .byte_valid(byte_valid),
    .byte_data (rx_byte),
    .byte_err  (byte_err),
    .busy      (rx_busy)
  );

  assign en_rise = load_enb && !en_q;
  assign en_fall = !load_enb && en_q;

  always_comb begin
    word_d = word_q;
    word_d[8*byte_idx_q +: 8] = rx_byte;
  end

  assign gap_expire = !rx_busy && (byte_idx_q != '0) && (gap_q == GapW'(GapCycles - 1));

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      gap_q <= '0;
    end else if (rx_busy || (byte_idx_q == '0) || gap_expire) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + GapW'(1);
    end
  end

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      en_q        <= 1'b0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      en_q   <= load_enb;
      flag_q <= 1'b0;
      if (byte_valid) begin
        if (byte_idx_q == LastIdx) begin
          // Address uses the pre-update base/count even if load_enb rises now.
          flag_q     <= 1'b1;
          addr_q     <= base_q + count_q;
          data_q     <= word_d;
          count_q    <= count_q + ADDR_W'(1);
          byte_idx_q <= '0;
        end else begin
          word_q     <= word_d;
          byte_idx_q <= byte_idx_q + IdxW'(1);
        end
      end else if (gap_expire) begin
        byte_idx_q <= '0;
      end
      if (byte_err) begin
        frame_err_q <= 1'b1;
      end
      if (en_rise) begin
        base_q      <= base_addr;
        count_q     <= '0;
        frame_err_q <= 1'b0;
        byte_idx_q  <= '0;
      end
      if (en_fall) begin
        byte_idx_q <= '0;
      end
    end
  end

  assign ram.RAM_write_flag = flag_q;
  assign ram.RAM_write_addr = addr_q;
  assign ram.RAM_write_data = data_q;
  assign busy               = rx_busy;
  assign word_count         = count_q;
  assign frame_err          = frame_err_q;

endmodule
